// File: rtl/ssd_rx_decoder.sv
// rtl/ssd_rx_decoder.sv - seven-segment serial link receiver and hex decoder
module ssd_rx_decoder #(
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       s_clk,
   input  logic       s_data,
   input  logic       s_latch,
   output logic [3:0] code,
   output logic       blank,
   output logic       valid,
   output logic       err_frame,
   output logic       err_code,
   output logic [6:0] seg_raw
);

   logic [SYNC_STAGES-1:0] r_clk_sync;
   logic [SYNC_STAGES-1:0] r_data_sync;
   logic [SYNC_STAGES-1:0] r_latch_sync;
   logic                   r_clk_prev;
   logic                   r_latch_prev;
   logic                   r_clk_rise;
   logic                   r_latch_rise;
   logic                   r_data_q;
   logic                   r_latch_pend;
   logic [6:0]             r_shift;
   logic [3:0]             r_cnt;
   logic [3:0]             r_code;
   logic                   r_blank;
   logic                   r_valid;
   logic                   r_err_frame;
   logic                   r_err_code;
   logic [6:0]             r_seg_raw;

   logic                   w_clk_rise;
   logic                   w_latch_rise;
   logic [3:0]             w_cnt_inc;
   logic                   w_hit;
   logic [3:0]             w_code;
   logic                   w_is_blank;

   assign w_clk_rise   = r_clk_sync[SYNC_STAGES-1] & ~r_clk_prev;
   assign w_latch_rise = r_latch_sync[SYNC_STAGES-1] & ~r_latch_prev;
   assign w_cnt_inc    = (r_cnt == 4'd8) ? 4'd8 : r_cnt + 4'd1;
   assign w_is_blank   = (r_shift == 7'b1111111);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_clk_sync   <= '0;
         r_data_sync  <= '0;
         r_latch_sync <= '0;
         r_clk_prev   <= 1'b0;
         r_latch_prev <= 1'b0;
         r_clk_rise   <= 1'b0;
         r_latch_rise <= 1'b0;
         r_data_q     <= 1'b0;
      end else begin
         r_clk_sync   <= {r_clk_sync[SYNC_STAGES-2:0], s_clk};
         r_data_sync  <= {r_data_sync[SYNC_STAGES-2:0], s_data};
         r_latch_sync <= {r_latch_sync[SYNC_STAGES-2:0], s_latch};
         r_clk_prev   <= r_clk_sync[SYNC_STAGES-1];
         r_latch_prev <= r_latch_sync[SYNC_STAGES-1];
         r_clk_rise   <= w_clk_rise;
         r_latch_rise <= w_latch_rise;
         r_data_q     <= r_data_sync[SYNC_STAGES-1];
      end
   end

   // The latch is evaluated one cycle after the shift, so a 7th bit arriving
   // together with the latch is already in r_shift/r_cnt when it is judged.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_shift      <= 7'd0;
         r_cnt        <= 4'd0;
         r_latch_pend <= 1'b0;
      end else begin
         r_latch_pend <= r_latch_rise;
         if (r_clk_rise)
            r_shift <= {r_shift[5:0], r_data_q};
         if (r_latch_pend)
            r_cnt <= r_clk_rise ? 4'd1 : 4'd0;
         else if (r_clk_rise)
            r_cnt <= w_cnt_inc;
      end
   end

   always_comb begin
      w_hit  = 1'b1;
      w_code = 4'h0;
      case (r_shift)
         7'b1000000: w_code = 4'h0;
         7'b1111001: w_code = 4'h1;
         7'b0100100: w_code = 4'h2;
         7'b0110000: w_code = 4'h3;
         7'b0011001: w_code = 4'h4;
         7'b0010010: w_code = 4'h5;
         7'b0000010: w_code = 4'h6;
         7'b1111000: w_code = 4'h7;
         7'b0000000: w_code = 4'h8;
         7'b0010000: w_code = 4'h9;
         7'b0001000: w_code = 4'hA;
         7'b0000011: w_code = 4'hB;
         7'b1000110: w_code = 4'hC;
         7'b0100001: w_code = 4'hD;
         7'b0000110: w_code = 4'hE;
         7'b0001110: w_code = 4'hF;
         default:    w_hit  = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_code      <= 4'h0;
         r_blank     <= 1'b1;
         r_valid     <= 1'b0;
         r_err_frame <= 1'b0;
         r_err_code  <= 1'b0;
         r_seg_raw   <= 7'b1111111;
      end else begin
         r_valid <= r_latch_pend;
         if (r_latch_pend) begin
            r_seg_raw <= r_shift;
            if (r_cnt != 4'd7) begin
               r_err_frame <= 1'b1;
               r_err_code  <= 1'b0;
            end else begin
               r_err_frame <= 1'b0;
               if (w_hit) begin
                  r_code     <= w_code;
                  r_blank    <= 1'b0;
                  r_err_code <= 1'b0;
               end else if (w_is_blank) begin
                  r_blank    <= 1'b1;
                  r_err_code <= 1'b0;
               end else begin
                  r_err_code <= 1'b1;
               end
            end
         end
      end
   end

   assign code      = r_code;
   assign blank     = r_blank;
   assign valid     = r_valid;
   assign err_frame = r_err_frame;
   assign err_code  = r_err_code;
   assign seg_raw   = r_seg_raw;

endmodule
